// File: rtl/regfile_param.sv
// Parametrised register file with an optional write-to-read bypass, a pending-write
// scoreboard for the hazard unit, and a sequential clear engine.
//
// After reset, or on clear_req, the engine zeroes one register per cycle and then
// raises ready. While the engine is clearing, the file ignores writes and issues,
// and both read ports return 0.
//
// Ports:
//   clock, reset_n        single clock; synchronous active-low reset
//   clear_req, ready      restart the clear sequence / file usable
//   RegWrite, rd,         write port
//   write_data
//   rs1, rs2,             combinational read ports
//   read_data1,
//   read_data2
//   issue_valid,          mark issue_rd as having an outstanding write
//   issue_rd
//   busy1, busy2          rs1 / rs2 have an outstanding write
module regfile_param #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            clear_req,
  output logic            ready,
  input  logic            RegWrite,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] write_data,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            busy1,
  output logic            busy2
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [NREGS-1:0]  pending_q, pending_d;
  logic [XLEN-1:0]   regs_q [NREGS];

  logic              run;
  logic              we_legal, iss_ok;
  logic              hit1, hit2;
  logic              reg_we;
  logic [AW-1:0]     reg_waddr;
  logic [XLEN-1:0]   reg_wdata;

  // Index range check; only matters when NREGS is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] idx);
    return 32'(idx) < NREGS;
  endfunction

  // True when idx names the hardwired zero register.
  function automatic logic is_zero(input logic [AW-1:0] idx);
    return ZERO_REG && (idx == '0);
  endfunction

  assign run   = (state_q == StRun);
  assign ready = run;

  // A write that happens together with clear_req is dropped, so it is not legal
  // and must not bypass either.
  assign we_legal = run && RegWrite && !clear_req && in_range(rd) && !is_zero(rd);
  assign iss_ok   = run && issue_valid && !clear_req && in_range(issue_rd) && !is_zero(issue_rd);

  assign hit1 = BYPASS && we_legal && (rd == rs1);
  assign hit2 = BYPASS && we_legal && (rd == rs2);

  // Next state, scoreboard update and register write select.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    pending_d = pending_q;
    reg_we    = 1'b0;
    reg_waddr = rd;
    reg_wdata = write_data;
    unique case (state_q)
      StClear: begin
        reg_we    = 1'b1;
        reg_waddr = clr_ptr_q;
        reg_wdata = '0;
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (32'(clr_ptr_q) == NREGS - 1) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (clear_req) begin
          state_d   = StClear;
          clr_ptr_d = '0;
          pending_d = '0;
        end else begin
          if (we_legal) begin
            reg_we        = 1'b1;
            pending_d[rd] = 1'b0;
          end
          // Set after clear: a new issue to the same index is the newer producer.
          if (iss_ok) begin
            pending_d[issue_rd] = 1'b1;
          end
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      pending_q <= pending_d;
    end
  end

  // Storage has no reset of its own; the clear engine zeroes it.
  always_ff @(posedge clock) begin
    if (reset_n && reg_we) begin
      regs_q[reg_waddr] <= reg_wdata;
    end
  end

  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (run && in_range(rs1) && !is_zero(rs1)) begin
      read_data1 = hit1 ? write_data : regs_q[rs1];
    end
    if (run && in_range(rs2) && !is_zero(rs2)) begin
      read_data2 = hit2 ? write_data : regs_q[rs2];
    end
  end

  // A bypassed read already sees the producer's data, so it is not a hazard.
  assign busy1 = run && in_range(rs1) && pending_q[rs1] && !hit1;
  assign busy2 = run && in_range(rs2) && pending_q[rs2] && !hit2;

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

  logic        clock = 1'b0;
  logic        reset_n;

  // Default configuration: XLEN=32, NREGS=32, BYPASS=1, ZERO_REG=1.
  logic        clear_req, ready, RegWrite, issue_valid, busy1, busy2;
  logic [4:0]  rd, rs1, rs2, issue_rd;
  logic [31:0] write_data, read_data1, read_data2;

  // Small configuration: NREGS=8, BYPASS=0, ZERO_REG=0.
  logic        clear_req_b, ready_b, we_b, iv_b, busy1_b, busy2_b;
  logic [2:0]  rd_b, rs1_b, rs2_b, ird_b;
  logic [31:0] wd_b, rd1_b, rd2_b;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  regfile_param dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear_req  (clear_req),
    .ready      (ready),
    .RegWrite   (RegWrite),
    .rd         (rd),
    .write_data (write_data),
    .rs1        (rs1),
    .rs2        (rs2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .busy1      (busy1),
    .busy2      (busy2)
  );

  regfile_param #(
    .XLEN    (32),
    .NREGS   (8),
    .BYPASS  (1'b0),
    .ZERO_REG(1'b0)
  ) dut_b (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear_req  (clear_req_b),
    .ready      (ready_b),
    .RegWrite   (we_b),
    .rd         (rd_b),
    .write_data (wd_b),
    .rs1        (rs1_b),
    .rs2        (rs2_b),
    .read_data1 (rd1_b),
    .read_data2 (rd2_b),
    .issue_valid(iv_b),
    .issue_rd   (ird_b),
    .busy1      (busy1_b),
    .busy2      (busy2_b)
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        iv;
    logic [4:0]  ird;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_a();
    clear_req = 0; RegWrite = 0; rd = 0; write_data = 0;
    rs1 = 0; rs2 = 0; issue_valid = 0; issue_rd = 0;
  endtask

  // Every index of the default instance must read 0 and be not busy.
  task automatic scan_zero(input string name);
    int bad = 0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(i);
      #1;
      if (read_data1 !== 0 || read_data2 !== 0 || busy1 !== 0 || busy2 !== 0) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  initial begin
    int n, nb, ok;
    idle_a();
    clear_req_b = 0; we_b = 0; rd_b = 0; wd_b = 0; rs1_b = 0; rs2_b = 0; iv_b = 0; ird_b = 0;

    // Reset clear.
    reset_n = 0;
    step(); step(); step();
    rs1 = 5; rs2 = 7;
    #1;
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset rd1", read_data1, 32'd0);
    chk("reset busy", 32'({busy1, busy2}), 32'd0);
    reset_n = 1;
    n = 0; nb = -1;
    while (!ready && n < 100) begin
      step();
      n++;
      if (ready_b && nb < 0) nb = n;
    end
    chk("reset edges32", 32'(n), 32'd32);
    chk("reset edges8", 32'(nb), 32'd8);
    scan_zero("reset scan");

    // Write/read, x0, bypass, scoreboard vectors (expected values before the edge).
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0};
    vecs[1]  = '{1, 0, 32'h12345678, 5, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0};
    vecs[2]  = '{0, 0, 32'h0,        5, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0};
    vecs[3]  = '{1, 7, 32'hA5A5A5A5, 7, 7, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0};
    vecs[4]  = '{0, 0, 32'h0,        7, 5, 0, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 0};
    vecs[5]  = '{0, 0, 32'h0,        3, 0, 1, 3, 32'h0, 32'h0, 0, 0};
    vecs[6]  = '{0, 0, 32'h0,        3, 3, 0, 0, 32'h0, 32'h0, 1, 1};
    vecs[7]  = '{1, 3, 32'h11111111, 3, 4, 1, 3, 32'h11111111, 32'h0, 0, 0};
    vecs[8]  = '{0, 0, 32'h0,        3, 3, 0, 0, 32'h11111111, 32'h11111111, 1, 1};
    vecs[9]  = '{1, 3, 32'h22222222, 3, 5, 0, 0, 32'h22222222, 32'hDEADBEEF, 0, 0};
    vecs[10] = '{0, 0, 32'h0,        3, 3, 0, 0, 32'h22222222, 32'h22222222, 0, 0};
    vecs[11] = '{0, 0, 32'h0,        0, 0, 1, 0, 32'h0, 32'h0, 0, 0};
    vecs[12] = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0, 32'h0, 0, 0};
    vecs[13] = '{1, 0, 32'hFFFFFFFF, 0, 7, 0, 0, 32'h0, 32'hA5A5A5A5, 0, 0};
    vecs[14] = '{1, 9, 32'h00000099, 9, 9, 1, 9, 32'h00000099, 32'h00000099, 0, 0};
    vecs[15] = '{0, 0, 32'h0,        9, 31, 0, 0, 32'h00000099, 32'h0, 1, 0};

    for (int i = 0; i < 16; i++) begin
      RegWrite = vecs[i].we; rd = vecs[i].rd; write_data = vecs[i].wd;
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
      #1;
      chk($sformatf("v%0d rd1", i), read_data1, vecs[i].e1);
      chk($sformatf("v%0d rd2", i), read_data2, vecs[i].e2);
      chk($sformatf("v%0d busy1", i), 32'(busy1), 32'(vecs[i].eb1));
      chk($sformatf("v%0d busy2", i), 32'(busy2), 32'(vecs[i].eb2));
      step();
    end
    idle_a();

    // Small configuration: no bypass, ordinary register 0.
    we_b = 1; rd_b = 0; wd_b = 32'h12345678; rs1_b = 0; rs2_b = 0;
    #1; chk("b nobypass x0", rd1_b, 32'h0);
    step();
    rd_b = 7; wd_b = 32'hA5A5A5A5; rs1_b = 7; rs2_b = 0;
    #1;
    chk("b nobypass r7", rd1_b, 32'h0);
    chk("b x0 ordinary", rd2_b, 32'h12345678);
    step();
    we_b = 0;
    #1; chk("b r7 after", rd1_b, 32'hA5A5A5A5);
    iv_b = 1; ird_b = 0;
    step();
    iv_b = 0; rs1_b = 0;
    #1; chk("b busy x0", 32'(busy1_b), 32'd1);
    we_b = 1; rd_b = 0; wd_b = 32'h1;
    #1;
    chk("b busy same cycle", 32'(busy1_b), 32'd1);
    chk("b old data", rd1_b, 32'h12345678);
    step();
    we_b = 0;
    #1;
    chk("b busy cleared", 32'(busy1_b), 32'd0);
    chk("b new data", rd1_b, 32'h1);

    // Clear request mid-operation.
    for (int i = 1; i <= 4; i++) begin
      RegWrite = 1; rd = 5'(i); write_data = 32'h100 + 32'(i);
      step();
    end
    RegWrite = 0; issue_valid = 1; issue_rd = 2;
    step();
    issue_valid = 0; rs1 = 2; rs2 = 4;
    #1;
    chk("pre-clear busy", 32'(busy1), 32'd1);
    chk("pre-clear r4", read_data2, 32'h104);
    clear_req = 1; RegWrite = 1; rd = 9; write_data = 32'hCAFEF00D;
    step();
    // Writes and issues while clearing must be ignored.
    clear_req = 0; RegWrite = 1; rd = 6; write_data = 32'h66666666;
    issue_valid = 1; issue_rd = 6; rs1 = 2; rs2 = 9;
    n = 0; ok = 1;
    while (!ready && n < 100) begin
      #1;
      if (busy1 || busy2 || read_data1 != 0 || read_data2 != 0) ok = 0;
      step();
      n++;
    end
    idle_a();
    chk("clear edges", 32'(n), 32'd32);
    chk("clear quiet", 32'(ok), 32'd1);
    scan_zero("clear scan");

    // Reset in the middle of a clear.
    clear_req = 1;
    step();
    clear_req = 0;
    for (int i = 0; i < 10; i++) step();
    reset_n = 0;
    step();
    chk("midclear reset ready", 32'(ready), 32'd0);
    reset_n = 1;
    n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
    chk("midclear edges", 32'(n), 32'd32);
    scan_zero("midclear scan");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
